cfg_intr_responder: RTL and testbench
=====================================

// Module: cfg_intr_responder
// PURPOSE
//  Endpoint-core side of the cfg_interrupt handshake.
//  - Accepts interrupt requests from the user interrupt controller.
//  - Turns each request into an outbound message: MSI write, Assert_INTA or Deassert_INTA.
//  - Returns cfg_interrupt_rdy_n once the message has been accepted downstream.
//  - Generates cfg_interrupt_legacyclr on a host clear.
//  Sits between the interrupt controller and the TX message path, in place of the hard-core config interrupt logic.
// PARAMETERS
//  RDY_LATENCY  4             wait cycles between request capture and message presentation (>=1)
//  MSI_ADDR     32'hFEE0_0000 address driven on msg_addr_o for MSI
//  MSI_DATA     16'h0000      data driven on msg_data_o for MSI
//  CNT_W        16            width of irq_count_o
// PORTS
//  clk                        in   1      single clock; all logic on rising edge
//  rst_n                      in   1      asynchronous, active-low reset
//  cfg_interrupt_n_i          in   1      request, active low; held low until rdy
//  cfg_interrupt_assert_n_i   in   1      legacy only: 0=assert INTA, 1=deassert INTA
//  cfg_interrupt_rdy_n_o      out  1      request accepted, active-low 1-cycle pulse
//  msi_enable_i               in   1      1=MSI mode, 0=legacy INTx; sampled at request capture
//  host_intclr_i              in   1      1-cycle strobe: host cleared the legacy interrupt
//  cfg_interrupt_legacyclr_o  out  1      1-cycle pulse to the controller
//  msg_valid_o                out  1      message valid
//  msg_ready_i                in   1      downstream accept
//  msg_type_o                 out  2      0=MSI write, 1=Assert_INTA, 2=Deassert_INTA
//  msg_addr_o                 out  32     MSI_ADDR for MSI, else 0
//  msg_data_o                 out  16     MSI_DATA for MSI, else 0
//  intx_asserted_o            out  1      current virtual INTA wire state
//  irq_count_o                out  CNT_W  MSI + Assert_INTA handshakes, saturating
//  proto_err_o                out  1      sticky: request withdrawn before rdy
// BEHAVIOUR
//  Reset values:
//  - rdy_n_o=1, msg_valid_o=0, legacyclr_o=0, intx_asserted_o=0, irq_count_o=0, proto_err_o=0.
//  - msg_type/addr/data=0; FSM in IDLE.
//  FSM states:
//  - IDLE: on cfg_interrupt_n_i==0, capture msi_enable_i and assert_n, load counter=RDY_LATENCY, go WAIT.
//  - WAIT: decrement the counter. At 0, go SEND, except for a redundant legacy request (assert while intx_asserted_o=1, or deassert while 0), which goes straight to RDY with no message.
//  - SEND: msg_valid_o=1 with type/addr/data stable until msg_ready_i. On handshake go RDY; intx_asserted_o updates to the sent assert/deassert; irq_count_o += 1 for MSI or Assert, saturating at all-ones.
//  - RDY: cfg_interrupt_rdy_n_o=0 for exactly one cycle, then GAP.
//  - GAP: one cycle in which the request is ignored, so the controller can release it; then IDLE.
//  Latency with msg_ready_i held 1:
//  - rdy_n_o low RDY_LATENCY+2 cycles after the capture edge.
//  - msg_valid_o high RDY_LATENCY+1 cycles after the capture edge, for one cycle.
//  Request withdrawn (cfg_interrupt_n_i=1) before RDY:
//  - In WAIT: set proto_err_o and go IDLE with no message and no rdy.
//  - In SEND: the message is held until handshake (valid never drops), then IDLE, no rdy, proto_err_o set.
//  msi_enable_i changes mid-request: ignored; the captured mode is used.
//  Legacy clear:
//  - host_intclr_i with intx_asserted_o=1 gives legacyclr_o=1 on the next cycle, for one cycle.
//  - Ignored when intx_asserted_o=0.
//  - Independent of the FSM; a coincident request proceeds normally.
//  - A deassert handshake in the same cycle still yields the pulse if intx was 1 at sampling.
//  Mid-operation reset: all state returns to reset values immediately, including dropping msg_valid_o.
// TESTING
//  1. MSI: msi_en=1, RDY_LATENCY=4, ready=1, int_n low at edge 0 -> valid at edge 5 (type 0, addr FEE00000); rdy_n low at edge 6 only; count=1.
//  2. Legacy pair: assert request, then deassert request -> types 1 then 2; intx 1 then 0; count=1; each request gets exactly one rdy pulse.
//  3. Back-pressure: ready=0 for 10 cycles in SEND -> valid held, fields stable, rdy_n stays 1; rdy pulse one cycle after ready=1.
//  4. Redundant assert while intx=1 -> no msg_valid_o; rdy after RDY_LATENCY+1; count unchanged.
//  5. Withdraw int_n in WAIT -> no msg, no rdy, proto_err=1 until reset. Host clear with intx=1 -> one legacyclr pulse; with intx=0 -> none.

Source files
------------

// File: rtl/cfg_intr_responder_if.sv
// Bundle of cfg_interrupt request/acknowledge signals and the outbound message channel.
// The requester drives through the master view; the responder core uses the slave view.
interface cfg_intr_responder_if #(
  parameter int CNT_W = 16
);
  logic             cfg_interrupt_n_i;
  logic             cfg_interrupt_assert_n_i;
  logic             cfg_interrupt_rdy_n_o;
  logic             msi_enable_i;
  logic             host_intclr_i;
  logic             cfg_interrupt_legacyclr_o;
  logic             msg_valid_o;
  logic             msg_ready_i;
  logic [1:0]       msg_type_o;
  logic [31:0]      msg_addr_o;
  logic [15:0]      msg_data_o;
  logic             intx_asserted_o;
  logic [CNT_W-1:0] irq_count_o;
  logic             proto_err_o;

  modport master (
    output cfg_interrupt_n_i, cfg_interrupt_assert_n_i, msi_enable_i,
           host_intclr_i, msg_ready_i,
    input  cfg_interrupt_rdy_n_o, cfg_interrupt_legacyclr_o, msg_valid_o,
           msg_type_o, msg_addr_o, msg_data_o, intx_asserted_o,
           irq_count_o, proto_err_o
  );

  modport slave (
    input  cfg_interrupt_n_i, cfg_interrupt_assert_n_i, msi_enable_i,
           host_intclr_i, msg_ready_i,
    output cfg_interrupt_rdy_n_o, cfg_interrupt_legacyclr_o, msg_valid_o,
           msg_type_o, msg_addr_o, msg_data_o, intx_asserted_o,
           irq_count_o, proto_err_o
  );
endinterface

// File: rtl/cfg_intr_responder.sv
// Endpoint-side cfg_interrupt responder: turns each controller request into an MSI or
// Assert/Deassert_INTA message, acknowledges with rdy_n, and forwards host legacy clears.
module cfg_intr_responder #(
  parameter int          RDY_LATENCY = 4,
  parameter logic [31:0] MSI_ADDR    = 32'hFEE0_0000,
  parameter logic [15:0] MSI_DATA    = 16'h0000,
  parameter int          CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cfg_intr_responder_if.slave bus
);
  localparam int LAT_W = $clog2(RDY_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, WAIT, SEND, RDY, GAP} state_t;

  state_t           state_reg, state_next;
  logic [LAT_W-1:0] cnt_reg, cnt_next;
  logic             msi_reg, msi_next;
  logic             asrt_n_reg, asrt_n_next;
  logic             withdrawn_reg, withdrawn_next;
  logic             intx_reg, intx_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             perr_reg, perr_next;
  logic             lclr_reg;
  logic             redundant;

  // A legacy request that would not change the virtual wire produces no message.
  assign redundant = !msi_reg && ((!asrt_n_reg) == intx_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      msi_reg       <= 1'b0;
      asrt_n_reg    <= 1'b1;
      withdrawn_reg <= 1'b0;
      intx_reg      <= 1'b0;
      count_reg     <= '0;
      perr_reg      <= 1'b0;
      lclr_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      msi_reg       <= msi_next;
      asrt_n_reg    <= asrt_n_next;
      withdrawn_reg <= withdrawn_next;
      intx_reg      <= intx_next;
      count_reg     <= count_next;
      perr_reg      <= perr_next;
      lclr_reg      <= bus.host_intclr_i && intx_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    msi_next       = msi_reg;
    asrt_n_next    = asrt_n_reg;
    withdrawn_next = withdrawn_reg;
    intx_next      = intx_reg;
    count_next     = count_reg;
    perr_next      = perr_reg;
    case (state_reg)
      IDLE: begin
        if (!bus.cfg_interrupt_n_i) begin
          msi_next       = bus.msi_enable_i;
          asrt_n_next    = bus.cfg_interrupt_assert_n_i;
          cnt_next       = LAT_W'(RDY_LATENCY);
          withdrawn_next = 1'b0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if (bus.cfg_interrupt_n_i) begin
          perr_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          state_next = redundant ? RDY : SEND;
        end else begin
          cnt_next = cnt_reg - LAT_W'(1);
        end
      end
      SEND: begin
        // A withdrawn request still completes its message but loses the rdy pulse.
        if (bus.cfg_interrupt_n_i) begin
          withdrawn_next = 1'b1;
          perr_next      = 1'b1;
        end
        if (bus.msg_ready_i) begin
          if (!msi_reg) begin
            intx_next = !asrt_n_reg;
          end
          if ((msi_reg || !asrt_n_reg) && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + CNT_W'(1);
          end
          state_next = (withdrawn_reg || bus.cfg_interrupt_n_i) ? IDLE : RDY;
        end
      end
      RDY:     state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.msg_valid_o               = (state_reg == SEND);
  assign bus.msg_type_o                = ((state_reg != SEND) || msi_reg) ? 2'd0 :
                                         (asrt_n_reg ? 2'd2 : 2'd1);
  assign bus.msg_addr_o                = ((state_reg == SEND) && msi_reg) ? MSI_ADDR : 32'h0;
  assign bus.msg_data_o                = ((state_reg == SEND) && msi_reg) ? MSI_DATA : 16'h0;
  assign bus.cfg_interrupt_rdy_n_o     = (state_reg != RDY);
  assign bus.cfg_interrupt_legacyclr_o = lclr_reg;
  assign bus.intx_asserted_o           = intx_reg;
  assign bus.irq_count_o               = count_reg;
  assign bus.proto_err_o               = perr_reg;
endmodule

// File: tb/tb_cfg_intr_responder.sv
// Bench for cfg_intr_responder: vector table, directed corner cases, then randomized
// requests checked against a transaction-level model of the interrupt handshake.
module tb_cfg_intr_responder;
  localparam int          L     = 4;
  localparam int          CW    = 3;
  localparam logic [31:0] MSI_A = 32'hFEE0_0000;
  localparam logic [15:0] MSI_D = 16'hBEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cfg_intr_responder_if #(.CNT_W(CW)) bus();

  cfg_intr_responder #(
    .RDY_LATENCY(L), .MSI_ADDR(MSI_A), .MSI_DATA(MSI_D), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int          errors = 0;
  int          checks = 0;
  bit          m_intx = 1'b0;
  bit          m_perr = 1'b0;
  bit          rand_clr = 1'b0;
  logic [CW-1:0] m_count = '0;

  typedef struct {
    logic int_n, msi, an, rdy, clr;
    logic valid, rdy_n;
    logic [1:0] typ;
    logic intx;
    logic [CW-1:0] cnt;
    logic lclr;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; the model applies any handshake at the edge, legacy clear uses pre-edge intx.
  task automatic advance(input bit hs, input bit hs_msi, input bit hs_an);
    bit exp_clr;
    exp_clr = bus.host_intclr_i && m_intx;
    if (hs) begin
      if (!hs_msi) m_intx = !hs_an;
      if ((hs_msi || !hs_an) && (m_count != {CW{1'b1}})) m_count = m_count + CW'(1);
    end
    @(negedge clk);
    chk("legacyclr", 32'(bus.cfg_interrupt_legacyclr_o), 32'(exp_clr));
    chk("intx", 32'(bus.intx_asserted_o), 32'(m_intx));
    chk("count", 32'(bus.irq_count_o), 32'(m_count));
    chk("proto_err", 32'(bus.proto_err_o), 32'(m_perr));
    $display("cyc t=%0t int_n=%0b valid=%0b rdy_n=%0b intx=%0b cnt=%0d", $time,
             bus.cfg_interrupt_n_i, bus.msg_valid_o, bus.cfg_interrupt_rdy_n_o,
             bus.intx_asserted_o, bus.irq_count_o);
    bus.host_intclr_i = rand_clr ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // One complete request; wd_wait=k withdraws at the k-th WAIT edge (1..L+1), -1 never.
  task automatic run_req(input bit msi, input bit an, input int wd_wait, input bit wd_send,
                         input int bp);
    bit         red;
    logic [1:0] etype;
    red   = !msi && ((an == 1'b0) == m_intx);
    etype = msi ? 2'd0 : (an ? 2'd2 : 2'd1);
    $display("req msi=%0b assert_n=%0b wd_wait=%0d wd_send=%0b bp=%0d redundant=%0b",
             msi, an, wd_wait, wd_send, bp, red);
    bus.cfg_interrupt_n_i        = 1'b0;
    bus.msi_enable_i             = msi;
    bus.cfg_interrupt_assert_n_i = an;
    bus.msg_ready_i              = 1'($urandom);
    advance(1'b0, 1'b0, 1'b0);
    chk("wait_valid", 32'(bus.msg_valid_o), 0);
    chk("wait_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 1);
    for (int k = 1; k <= L + 1; k++) begin
      bus.msi_enable_i             = 1'($urandom);
      bus.cfg_interrupt_assert_n_i = 1'($urandom);
      bus.msg_ready_i              = 1'($urandom);
      if (wd_wait == k) begin
        bus.cfg_interrupt_n_i = 1'b1;
        m_perr = 1'b1;
        advance(1'b0, 1'b0, 1'b0);
        chk("wd_valid", 32'(bus.msg_valid_o), 0);
        chk("wd_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 1);
        advance(1'b0, 1'b0, 1'b0);
        chk("wd_idle_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 1);
        return;
      end
      advance(1'b0, 1'b0, 1'b0);
      if (k <= L) begin
        chk("wait_valid", 32'(bus.msg_valid_o), 0);
        chk("wait_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 1);
      end
    end
    if (red) begin
      chk("red_valid", 32'(bus.msg_valid_o), 0);
      chk("red_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 0);
      bus.cfg_interrupt_n_i = 1'b1;
      advance(1'b0, 1'b0, 1'b0);
      chk("red_gap_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 1);
      advance(1'b0, 1'b0, 1'b0);
      return;
    end
    for (int b = 0; b <= bp; b++) begin
      chk("send_valid", 32'(bus.msg_valid_o), 1);
      chk("send_type", 32'(bus.msg_type_o), 32'(etype));
      chk("send_addr", bus.msg_addr_o, msi ? MSI_A : 32'h0);
      chk("send_data", 32'(bus.msg_data_o), msi ? 32'(MSI_D) : 0);
      chk("send_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 1);
      bus.msg_ready_i  = (b == bp);
      bus.msi_enable_i = 1'($urandom);
      if (wd_send) begin
        bus.cfg_interrupt_n_i = 1'b1;
        m_perr = 1'b1;
      end
      advance(b == bp, msi, an);
    end
    chk("post_valid", 32'(bus.msg_valid_o), 0);
    chk("post_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), wd_send ? 1 : 0);
    bus.cfg_interrupt_n_i = 1'b1;
    advance(1'b0, 1'b0, 1'b0);
    chk("gap_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 1);
    advance(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_interrupt_n_i = 1'b1; bus.cfg_interrupt_assert_n_i = 1'b1;
    bus.msi_enable_i = 1'b0; bus.host_intclr_i = 1'b0; bus.msg_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 1);
    chk("rst_valid", 32'(bus.msg_valid_o), 0);
    chk("rst_lclr", 32'(bus.cfg_interrupt_legacyclr_o), 0);
    chk("rst_intx", 32'(bus.intx_asserted_o), 0);
    chk("rst_count", 32'(bus.irq_count_o), 0);
    chk("rst_perr", 32'(bus.proto_err_o), 0);
    chk("rst_type", 32'(bus.msg_type_o), 0);
    chk("rst_addr", bus.msg_addr_o, 0);
    chk("rst_data", 32'(bus.msg_data_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MSI request then legacy assert with a host clear, one row per clock edge.
    for (int i = 0; i < 5; i++)
      tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd1, 1'b0};
    for (int i = 9; i < 14; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 3'd1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd2, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 3'd2, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 3'd2, 1'b0};
    for (int i = 0; i < 18; i++) begin
      bus.cfg_interrupt_n_i = tbl[i].int_n; bus.msi_enable_i = tbl[i].msi;
      bus.cfg_interrupt_assert_n_i = tbl[i].an; bus.msg_ready_i = tbl[i].rdy;
      bus.host_intclr_i = tbl[i].clr;
      @(negedge clk);
      $display("vec %0d valid=%0b rdy_n=%0b type=%0d intx=%0b cnt=%0d lclr=%0b", i,
               bus.msg_valid_o, bus.cfg_interrupt_rdy_n_o, bus.msg_type_o,
               bus.intx_asserted_o, bus.irq_count_o, bus.cfg_interrupt_legacyclr_o);
      chk("vec_valid", 32'(bus.msg_valid_o), 32'(tbl[i].valid));
      chk("vec_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 32'(tbl[i].rdy_n));
      if (tbl[i].valid) begin
        chk("vec_type", 32'(bus.msg_type_o), 32'(tbl[i].typ));
        chk("vec_addr", bus.msg_addr_o, (tbl[i].typ == 2'd0) ? MSI_A : 32'h0);
        chk("vec_data", 32'(bus.msg_data_o), (tbl[i].typ == 2'd0) ? 32'(MSI_D) : 0);
      end
      chk("vec_intx", 32'(bus.intx_asserted_o), 32'(tbl[i].intx));
      chk("vec_count", 32'(bus.irq_count_o), 32'(tbl[i].cnt));
      chk("vec_lclr", 32'(bus.cfg_interrupt_legacyclr_o), 32'(tbl[i].lclr));
      chk("vec_perr", 32'(bus.proto_err_o), 0);
    end
    bus.host_intclr_i = 1'b0;
    m_intx = 1'b1; m_count = 3'd2; m_perr = 1'b0;

    run_req(1'b0, 1'b1, -1, 1'b0, 0);      // deassert: type 2, intx back to 0
    bus.host_intclr_i = 1'b1;              // host clear while intx=0: no pulse
    advance(1'b0, 1'b0, 1'b0);
    run_req(1'b1, 1'b1, -1, 1'b0, 10);     // back-pressure for 10 cycles
    run_req(1'b0, 1'b0, -1, 1'b0, 0);      // assert
    run_req(1'b0, 1'b0, -1, 1'b0, 0);      // redundant assert
    bus.host_intclr_i = 1'b1;              // host clear while intx=1: one pulse
    advance(1'b0, 1'b0, 1'b0);
    advance(1'b0, 1'b0, 1'b0);
    run_req(1'b1, 1'b1, 2, 1'b0, 0);       // withdraw in WAIT
    run_req(1'b0, 1'b1, -1, 1'b1, 3);      // withdraw in SEND, message still completes

    rand_clr = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int wd;
      bit ws;
      wd = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, L + 1)) : -1;
      ws = (wd < 0) && ($urandom_range(0, 7) == 0);
      run_req(1'($urandom), 1'($urandom), wd, ws, int'($urandom_range(0, 4)));
    end

    // Asynchronous reset while a message is presented.
    rand_clr = 1'b0;
    bus.host_intclr_i = 1'b0;
    bus.cfg_interrupt_n_i = 1'b0; bus.msi_enable_i = 1'b1; bus.msg_ready_i = 1'b0;
    repeat (L + 2) advance(1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(bus.msg_valid_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.msg_valid_o), 0);
    chk("midrst_count", 32'(bus.irq_count_o), 0);
    chk("midrst_intx", 32'(bus.intx_asserted_o), 0);
    chk("midrst_perr", 32'(bus.proto_err_o), 0);
    chk("midrst_rdy_n", 32'(bus.cfg_interrupt_rdy_n_o), 1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
